// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: lights one pseudo-random mole per round and
// scores each round as a hit (its own switch toggled) or a miss.
module mole_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000000,
  parameter int unsigned ROUNDS         = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] sw,
  output logic [15:0] LED,
  output logic [5:0]  score,
  output logic [5:0]  misses,
  output logic [5:0]  round,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]  ROUNDS_L   = 6'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_SHOW,
    S_HIT,
    S_MISS,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] sw_q;
  logic [15:0] toggle;
  logic [3:0]  target_q, target_d;
  logic [3:0]  pick;
  logic [31:0] timer_q, timer_d;
  logic [5:0]  score_q, score_d;
  logic [5:0]  misses_q, misses_d;
  logic [5:0]  round_q, round_d;

  // Galois form, taps 16,14,13,11 (mask 0xB400), shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign toggle = sw ^ sw_q;
  assign pick   = lfsr_q[3:0];

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_next(lfsr_q);
    target_d = target_q;
    timer_d  = timer_q;
    score_d  = score_q;
    misses_d = misses_q;
    round_d  = round_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_PICK;
          score_d  = '0;
          misses_d = '0;
          round_d  = '0;
        end
      end
      S_PICK: begin
        // Never repeat the previous mole back to back.
        target_d = (pick == target_q) ? pick + 4'd1 : pick;
        timer_d  = '0;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        timer_d = timer_q + 32'd1;
        if (toggle[target_q]) begin
          state_d = S_HIT;
        end else if (|toggle) begin
          state_d = S_MISS;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_MISS;
        end
      end
      S_HIT: begin
        score_d = score_q + 6'd1;
        round_d = round_q + 6'd1;
        state_d = (round_d == ROUNDS_L) ? S_DONE : S_PICK;
      end
      S_MISS: begin
        misses_d = misses_q + 6'd1;
        round_d  = round_q + 6'd1;
        state_d  = (round_d == ROUNDS_L) ? S_DONE : S_PICK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    sw_q <= sw;
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      target_q <= '0;
      timer_q  <= '0;
      score_q  <= '0;
      misses_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      round_q  <= round_d;
    end
  end

  always_comb begin
    LED = 16'h0000;
    case (state_q)
      S_SHOW:  LED = 16'h0001 << target_q;
      S_DONE:  LED = 16'hFFFF;
      default: LED = 16'h0000;
    endcase
  end

  assign busy   = (state_q == S_PICK) || (state_q == S_SHOW) ||
                  (state_q == S_HIT)  || (state_q == S_MISS);
  assign done   = (state_q == S_DONE);
  assign score  = score_q;
  assign misses = misses_q;
  assign round  = round_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: a 4-round game instance and a 63-round
// instance used for long pick sequences with replays.
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [15:0] sw, sw2;
  logic [15:0] LED, LED2;
  logic [5:0]  score, misses, round;
  logic [5:0]  score2, misses2, round2;
  logic        busy, done, busy2, done2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mole_scheduler #(.TIMEOUT_CYCLES(8), .ROUNDS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sw(sw), .LED(LED),
    .score(score), .misses(misses), .round(round), .busy(busy), .done(done)
  );

  mole_scheduler #(.TIMEOUT_CYCLES(8), .ROUNDS(63)) u_dut63 (
    .clk(clk), .reset(reset), .start(start2), .sw(sw2), .LED(LED2),
    .score(score2), .misses(misses2), .round(round2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [15:0] v);
    idx_of = -1;
    for (int i = 0; i < 16; i++) if (v[i]) idx_of = i;
  endfunction

  task automatic wait_show(output int idx);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy && $onehot(LED)) begin
        idx = idx_of(LED);
        return;
      end
      step();
    end
    chk("show_timeout", 0, 1);
  endtask

  task automatic wait_show2(output int idx);
    idx = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy2 && $onehot(LED2)) begin
        idx = idx_of(LED2);
        return;
      end
      step();
    end
    chk("show2_timeout", 0, 1);
  endtask

  // Counts cycles the current SHOW stays lit, starting from its first cycle.
  task automatic show_len(output int n);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!$onehot(LED)) break;
      n++;
    end
  endtask

  int idx, w, n, prev, picks;

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; sw = 16'h0000; sw2 = 16'h0000;
    step(); step();
    chk("rst_led", LED, 16'h0000);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_round", round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step();
    chk("idle_led", LED, 16'h0000);

    // Four straight hits.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("pick_busy", busy, 1);
    chk("pick_led", LED, 16'h0000);
    step();
    chk("show_onehot", $onehot(LED), 1);
    for (int r = 0; r < 4; r++) begin
      wait_show(idx);
      sw = sw ^ (16'h0001 << idx);
      step();
      chk("hit_led", LED, 16'h0000);
      step();
      chk("hit_score", score, r + 1);
    end
    chk("g1_done", done, 1);
    chk("g1_led", LED, 16'hFFFF);
    chk("g1_busy", busy, 0);
    chk("g1_score", score, 4);
    chk("g1_misses", misses, 0);
    chk("g1_round", round, 4);

    // Replay from DONE with no switch activity: every mole times out.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("g2_clr_score", score, 0);
    chk("g2_clr_round", round, 0);
    for (int r = 0; r < 4; r++) begin
      wait_show(idx);
      show_len(n);
      chk("timeout_len", n, 8);
      step();
      chk("timeout_misses", misses, r + 1);
    end
    chk("g2_done", done, 1);
    chk("g2_score", score, 0);
    chk("g2_misses", misses, 4);
    chk("g2_round", round, 4);

    // Right plus wrong switch together is a hit; wrong switch alone a miss.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_show(idx);
    w = (idx + 5) % 16;
    sw = sw ^ (16'h0001 << idx) ^ (16'h0001 << w);
    step();
    step();
    chk("both_score", score, 1);
    chk("both_misses", misses, 0);
    chk("both_round", round, 1);
    wait_show(idx);
    w = (idx + 3) % 16;
    sw = sw ^ (16'h0001 << w);
    step();
    chk("wrong_led", LED, 16'h0000);
    step();
    chk("wrong_score", score, 1);
    chk("wrong_misses", misses, 1);
    chk("wrong_round", round, 2);

    // Reset in the middle of a SHOW with two hits banked.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      wait_show(idx);
      sw = sw ^ (16'h0001 << idx);
      step();
    end
    wait_show(idx);
    chk("pre_rst_score", score, 2);
    sw = ~sw;
    reset = 1'b1;
    step();
    chk("mid_rst_led", LED, 16'h0000);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_misses", misses, 0);
    chk("mid_rst_round", round, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_show(idx);
    show_len(n);
    chk("post_rst_len", n, 8);
    step();
    chk("post_rst_misses", misses, 1);
    chk("post_rst_score", score, 0);

    // Long pick sequence on the 63-round instance, start pulsed during SHOW.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    prev = 0;
    picks = 0;
    for (int g = 0; g < 16; g++) begin
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int r = 0; r < 63; r++) begin
        wait_show2(idx);
        if (idx < 0) break;
        chk("tgt_ne_prev", (idx != prev), 1);
        prev = idx;
        picks++;
        sw2 = sw2 ^ (16'h0001 << idx);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
      end
      chk("g63_done", done2, 1);
      chk("g63_score", score2, 63);
      chk("g63_misses", misses2, 0);
      chk("g63_round", round2, 63);
    end
    chk("pick_count", picks, 1008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
